// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: controller for the register file's single write port.
// After reset it sweeps r1..r31 with INIT_VALUE. It then shares the port between
// the writeback stage, which has priority, and a 2-entry buffer of multiply/divide
// results. A starvation guard forces the buffer head through after STARVE_LIMIT
// consecutive denied cycles.
module regfile_write_arbiter #(
  parameter logic [31:0] INIT_VALUE   = 32'hFFFF_FFFF,
  parameter int          STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_valid,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  output logic        wb_stall,
  input  logic        md_valid,
  output logic        md_ready,
  input  logic [4:0]  md_addr,
  input  logic [31:0] md_data,
  output logic        rf_we,
  output logic [4:0]  rf_wr_addr,
  output logic [31:0] rf_wr_data,
  output logic        init_busy
);

  // Starvation counter must be able to hold STARVE_LIMIT itself (it saturates there).
  localparam int SW = (STARVE_LIMIT < 2) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e         state_q, state_d;
  logic [4:0]     sweep_q, sweep_d;
  logic [4:0]     fifo_addr_q [2];
  logic [31:0]    fifo_data_q [2];
  logic           rd_ptr_q, wr_ptr_q;
  logic [1:0]     count_q, count_d;
  logic [SW-1:0]  starve_q, starve_d;

  logic           fifo_empty_s;
  logic           force_s;
  logic           push_s;
  logic           pop_s;
  logic           grant_s;
  logic           we_s;
  logic [4:0]     addr_s;
  logic [31:0]    data_s;
  logic           stall_s;
  logic           ready_s;
  logic           busy_s;

  // Next-state logic and write-port grant: sweep in INIT, prioritised arbitration in RUN.
  always_comb begin
    state_d      = state_q;
    sweep_d      = sweep_q;
    pop_s        = 1'b0;
    grant_s      = 1'b0;
    addr_s       = 5'd0;
    data_s       = 32'd0;
    stall_s      = 1'b1;
    ready_s      = 1'b0;
    busy_s       = 1'b1;
    fifo_empty_s = (count_q == 2'd0);
    force_s      = (starve_q == STARVE_MAX) && !fifo_empty_s;
    case (state_q)
      ST_INIT: begin
        grant_s = 1'b1;
        addr_s  = sweep_q;
        data_s  = INIT_VALUE;
        sweep_d = sweep_q + 5'd1;
        if (sweep_q == 5'd31) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_INIT;
        end
      end
      ST_RUN: begin
        busy_s  = 1'b0;
        ready_s = (count_q < 2'd2);
        if (force_s) begin
          // Head has waited long enough: it takes the port and writeback holds.
          grant_s = 1'b1;
          pop_s   = 1'b1;
          addr_s  = fifo_addr_q[rd_ptr_q];
          data_s  = fifo_data_q[rd_ptr_q];
          stall_s = 1'b1;
        end else if (wb_valid) begin
          grant_s = 1'b1;
          addr_s  = wb_addr;
          data_s  = wb_data;
          stall_s = 1'b0;
        end else if (!fifo_empty_s) begin
          grant_s = 1'b1;
          pop_s   = 1'b1;
          addr_s  = fifo_addr_q[rd_ptr_q];
          data_s  = fifo_data_q[rd_ptr_q];
          stall_s = 1'b0;
        end else begin
          stall_s = 1'b0;
        end
      end
      default: begin
        state_d = ST_INIT;
        sweep_d = 5'd1;
      end
    endcase
    push_s = md_valid && ready_s;
    // A granted write to r0 is consumed silently.
    we_s   = grant_s && (addr_s != 5'd0);
  end

  // Buffer occupancy and starvation counter next-state.
  always_comb begin
    count_d  = count_q;
    starve_d = starve_q;
    if (push_s && !pop_s) begin
      count_d = count_q + 2'd1;
    end else if (!push_s && pop_s) begin
      count_d = count_q - 2'd1;
    end else begin
      count_d = count_q;
    end
    if ((state_q != ST_RUN) || fifo_empty_s || pop_s) begin
      starve_d = {SW{1'b0}};
    end else if (starve_q == STARVE_MAX) begin
      starve_d = starve_q;
    end else begin
      starve_d = starve_q + SW'(1);
    end
  end

  // Output drive: the write port stays quiet while reset is held.
  always_comb begin
    if (!reset) begin
      rf_we      = 1'b0;
      rf_wr_addr = 5'd0;
      rf_wr_data = 32'd0;
    end else begin
      rf_we      = we_s;
      rf_wr_addr = addr_s;
      rf_wr_data = data_s;
    end
    wb_stall  = stall_s;
    md_ready  = ready_s;
    init_busy = busy_s;
  end

  // Controller state and sweep address.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_INIT;
      sweep_q <= 5'd1;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
    end
  end

  // MD result buffer: two slots with wrap-around read/write pointers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fifo_addr_q[0] <= 5'd0;
      fifo_addr_q[1] <= 5'd0;
      fifo_data_q[0] <= 32'd0;
      fifo_data_q[1] <= 32'd0;
      rd_ptr_q       <= 1'b0;
      wr_ptr_q       <= 1'b0;
      count_q        <= 2'd0;
    end else begin
      if (push_s) begin
        fifo_addr_q[wr_ptr_q] <= md_addr;
        fifo_data_q[wr_ptr_q] <= md_data;
        wr_ptr_q              <= ~wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_d;
    end
  end

  // Starvation counter for the buffer head.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_q <= {SW{1'b0}};
    end else begin
      starve_q <= starve_d;
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter: directed vector table,
// hand-written multi-cycle sequences and randomized traffic against a
// queue-based reference model.
module tb_regfile_write_arbiter;

  localparam int          STARVE_LIMIT = 4;
  localparam logic [31:0] INIT_VALUE   = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_valid;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        wb_stall;
  logic        md_valid;
  logic        md_ready;
  logic [4:0]  md_addr;
  logic [31:0] md_data;
  logic        rf_we;
  logic [4:0]  rf_wr_addr;
  logic [31:0] rf_wr_data;
  logic        init_busy;

  always #5 clk = ~clk;

  regfile_write_arbiter #(
    .INIT_VALUE   (INIT_VALUE),
    .STARVE_LIMIT (STARVE_LIMIT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .wb_valid   (wb_valid),
    .wb_addr    (wb_addr),
    .wb_data    (wb_data),
    .wb_stall   (wb_stall),
    .md_valid   (md_valid),
    .md_ready   (md_ready),
    .md_addr    (md_addr),
    .md_data    (md_data),
    .rf_we      (rf_we),
    .rf_wr_addr (rf_wr_addr),
    .rf_wr_data (rf_wr_data),
    .init_busy  (init_busy)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: sweep writes remaining, pending MD results, head wait time.
  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } md_ent_t;
  md_ent_t     mq[$];
  int          init_left = 31;
  int          wait_cnt  = 0;
  logic        m_we, m_stall, m_ready, m_busy;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  bit          m_push, m_pop;

  typedef struct {
    logic        wv;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        mv;
    logic [4:0]  ma;
    logic [31:0] md;
    logic        e_we;
    logic [4:0]  e_a;
    logic [31:0] e_d;
    logic        e_st;
    logic        e_rdy;
  } vec_t;
  vec_t vt[7];

  task automatic chk(string nm, logic e_we, logic [4:0] e_a, logic [31:0] e_d,
                     logic e_st, logic e_rdy, logic e_busy);
    checks++;
    if (rf_we !== e_we || rf_wr_addr !== e_a || rf_wr_data !== e_d ||
        wb_stall !== e_st || md_ready !== e_rdy || init_busy !== e_busy) begin
      errors++;
      $display("FAIL %s t=%0t: got we=%b addr=%0d data=%h stall=%b ready=%b busy=%b, expected we=%b addr=%0d data=%h stall=%b ready=%b busy=%b",
               nm, $time, rf_we, rf_wr_addr, rf_wr_data, wb_stall, md_ready, init_busy,
               e_we, e_a, e_d, e_st, e_rdy, e_busy);
    end
  endtask

  // Expected outputs for the current cycle from the model state and inputs.
  task automatic model_eval();
    m_push = 1'b0; m_pop = 1'b0; m_we = 1'b0; m_addr = 5'd0; m_data = 32'd0;
    m_stall = 1'b1; m_ready = 1'b0; m_busy = 1'b1;
    if (reset) begin
      if (init_left > 0) begin
        m_we   = 1'b1;
        m_addr = 5'(32 - init_left);
        m_data = INIT_VALUE;
      end else begin
        m_busy  = 1'b0;
        m_stall = 1'b0;
        m_ready = (mq.size() < 2);
        m_push  = md_valid && m_ready;
        if (mq.size() > 0 && wait_cnt >= STARVE_LIMIT) begin
          m_pop = 1'b1; m_stall = 1'b1; m_addr = mq[0].a; m_data = mq[0].d;
        end else if (wb_valid) begin
          m_addr = wb_addr; m_data = wb_data;
        end else if (mq.size() > 0) begin
          m_pop = 1'b1; m_addr = mq[0].a; m_data = mq[0].d;
        end
        m_we = (m_pop || wb_valid) && (m_addr != 5'd0);
      end
    end
  endtask

  // Advance the model across a clock edge.
  task automatic model_update();
    md_ent_t e;
    if (!reset) begin
      init_left = 31;
      mq.delete();
      wait_cnt = 0;
    end else if (init_left > 0) begin
      init_left--;
    end else begin
      if (m_pop) begin
        void'(mq.pop_front());
        wait_cnt = 0;
      end else if (mq.size() > 0) begin
        if (wait_cnt < STARVE_LIMIT) wait_cnt++;
      end else begin
        wait_cnt = 0;
      end
      if (m_push) begin
        e.a = md_addr; e.d = md_data;
        mq.push_back(e);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic cyc_model(string nm);
    #4;
    model_eval();
    chk(nm, m_we, m_addr, m_data, m_stall, m_ready, m_busy);
    tick();
  endtask

  task automatic cyc_exp(string nm, logic e_we, logic [4:0] e_a, logic [31:0] e_d,
                         logic e_st, logic e_rdy, logic e_busy);
    #4;
    model_eval();
    chk(nm, e_we, e_a, e_d, e_st, e_rdy, e_busy);
    tick();
  endtask

  task automatic set_in(logic wv, logic [4:0] wa, logic [31:0] wd,
                        logic mv, logic [4:0] ma, logic [31:0] md);
    wb_valid = wv; wb_addr = wa; wb_data = wd;
    md_valid = mv; md_addr = ma; md_data = md;
  endtask

  task automatic sweep_check(string nm);
    set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    for (int i = 1; i <= 31; i++) begin
      cyc_exp(nm, 1'b1, 5'(i), INIT_VALUE, 1'b1, 1'b0, 1'b1);
    end
    cyc_exp({nm, "_done"}, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    vt[0] = '{1'b1, 5'd5, 32'h0000_1234, 1'b0, 5'd0, 32'd0,         1'b1, 5'd5, 32'h0000_1234, 1'b0, 1'b1};
    vt[1] = '{1'b0, 5'd0, 32'd0,         1'b1, 5'd9, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'd0,         1'b0, 1'b1};
    vt[2] = '{1'b0, 5'd0, 32'd0,         1'b0, 5'd0, 32'd0,         1'b1, 5'd9, 32'hDEAD_BEEF, 1'b0, 1'b1};
    vt[3] = '{1'b1, 5'd0, 32'h0000_0055, 1'b0, 5'd0, 32'd0,         1'b0, 5'd0, 32'h0000_0055, 1'b0, 1'b1};
    vt[4] = '{1'b0, 5'd0, 32'd0,         1'b1, 5'd0, 32'h0000_0077, 1'b0, 5'd0, 32'd0,         1'b0, 1'b1};
    vt[5] = '{1'b0, 5'd0, 32'd0,         1'b0, 5'd0, 32'd0,         1'b0, 5'd0, 32'h0000_0077, 1'b0, 1'b1};
    vt[6] = '{1'b0, 5'd0, 32'd0,         1'b0, 5'd0, 32'd0,         1'b0, 5'd0, 32'd0,         1'b0, 1'b1};

    reset = 1'b0;
    set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    @(posedge clk);
    #1;
    // Outputs held quiet during reset, even with traffic offered.
    cyc_exp("reset_idle", 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 1'b1);
    set_in(1'b1, 5'd6, 32'h1, 1'b1, 5'd6, 32'h2);
    cyc_exp("reset_traffic", 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 1'b1);

    reset = 1'b1;
    sweep_check("sweep");

    // Directed vectors: WB only, MD only with one-cycle latency, r0 writes.
    for (int i = 0; i < 7; i++) begin
      set_in(vt[i].wv, vt[i].wa, vt[i].wd, vt[i].mv, vt[i].ma, vt[i].md);
      cyc_exp($sformatf("vec%0d", i), vt[i].e_we, vt[i].e_a, vt[i].e_d, vt[i].e_st, vt[i].e_rdy, 1'b0);
    end

    // Contention: WB wins STARVE_LIMIT cycles, then the forced MD write, then WB again.
    set_in(1'b1, 5'd7, 32'h0000_1111, 1'b1, 5'd3, 32'h0000_AAAA);
    cyc_exp("cont_push", 1'b1, 5'd7, 32'h0000_1111, 1'b0, 1'b1, 1'b0);
    md_valid = 1'b0;
    for (int k = 1; k <= STARVE_LIMIT; k++) begin
      cyc_exp($sformatf("cont_wb%0d", k), 1'b1, 5'd7, 32'h0000_1111, 1'b0, 1'b1, 1'b0);
    end
    cyc_exp("cont_force", 1'b1, 5'd3, 32'h0000_AAAA, 1'b1, 1'b1, 1'b0);
    cyc_exp("cont_wb_taken", 1'b1, 5'd7, 32'h0000_1111, 1'b0, 1'b1, 1'b0);

    // Backpressure: two pushes fill the buffer; a third offer waits for the forced pop.
    set_in(1'b1, 5'd8, 32'h0000_2222, 1'b1, 5'd10, 32'h0000_00A0);
    cyc_exp("bp_push0", 1'b1, 5'd8, 32'h0000_2222, 1'b0, 1'b1, 1'b0);
    md_addr = 5'd11; md_data = 32'h0000_00B1;
    cyc_exp("bp_push1", 1'b1, 5'd8, 32'h0000_2222, 1'b0, 1'b1, 1'b0);
    md_addr = 5'd12; md_data = 32'h0000_00C2;
    for (int k = 2; k <= 4; k++) begin
      cyc_exp($sformatf("bp_full%0d", k), 1'b1, 5'd8, 32'h0000_2222, 1'b0, 1'b0, 1'b0);
    end
    cyc_exp("bp_force", 1'b1, 5'd10, 32'h0000_00A0, 1'b1, 1'b0, 1'b0);
    md_valid = 1'b0;
    cyc_exp("bp_reopen", 1'b1, 5'd8, 32'h0000_2222, 1'b0, 1'b1, 1'b0);
    wb_valid = 1'b0;
    cyc_exp("bp_drain", 1'b1, 5'd11, 32'h0000_00B1, 1'b0, 1'b1, 1'b0);
    cyc_exp("bp_empty", 1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 1'b0);

    // Reset pulse with two entries buffered: buffer discarded, full sweep repeats.
    set_in(1'b1, 5'd8, 32'h0000_3333, 1'b1, 5'd13, 32'h0000_00D3);
    cyc_exp("rp_push0", 1'b1, 5'd8, 32'h0000_3333, 1'b0, 1'b1, 1'b0);
    md_addr = 5'd14; md_data = 32'h0000_00E4;
    cyc_exp("rp_push1", 1'b1, 5'd8, 32'h0000_3333, 1'b0, 1'b1, 1'b0);
    reset = 1'b0;
    set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    cyc_exp("rp_reset", 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 1'b1);
    reset = 1'b1;
    sweep_check("resweep");
    cyc_exp("rp_still_empty", 1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 1'b0);

    // Randomized traffic against the reference model, with occasional resets.
    for (int n = 0; n < 800; n++) begin
      reset    = ($urandom_range(0, 299) != 0);
      wb_valid = ($urandom_range(0, 99) < 55);
      wb_addr  = 5'($urandom_range(0, 31));
      wb_data  = $urandom;
      md_valid = ($urandom_range(0, 99) < 45);
      md_addr  = 5'($urandom_range(0, 31));
      md_data  = $urandom;
      cyc_model("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
